// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, digit count, output width and saturation limit.
package bin_to_bcd_seq_pkg;

    localparam int BIN_W     = 14;
    localparam int DIGITS    = 4;
    localparam int BCD_W     = 4 * DIGITS;
    localparam int MAX_VALUE = 9999;
    localparam int CNT_W     = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a value producer (master) and the converter (slave).
interface bin_to_bcd_seq_if
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_WIDTH = BIN_W
);
    logic                 start;
    logic [BIN_WIDTH-1:0] bin_in;
    logic                 busy;
    logic                 done;
    logic [BCD_W-1:0]     bcd_out;
    logic                 overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per input bit, result held
// in bcd_out until the next conversion completes.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_WIDTH = BIN_W
)(
    input  logic             clk,
    input  logic             rst,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int          CNT_LW   = $clog2(BIN_WIDTH + 1);
    localparam logic [31:0] MAX_U    = MAX_VALUE;
    localparam logic [CNT_LW-1:0] LAST_IT = CNT_LW'(BIN_WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_LW-1:0]    cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0]     scratch_q, scratch_d;
    logic [BCD_W-1:0]     scratch_adj;
    logic                 ovf_next_q, ovf_next_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;
    logic                 over_max;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (scratch_adj[4*g +: 4])
        );
    end

    assign over_max = (32'(bus.bin_in) > MAX_U);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        ovf_next_d = ovf_next_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_SHIFT;
                    shreg_d    = over_max ? BIN_WIDTH'(MAX_VALUE) : bus.bin_in;
                    scratch_d  = '0;
                    ovf_next_d = over_max;
                    cnt_d      = '0;
                end
            end
            ST_SHIFT: begin
                // Correction is applied to the digits before they are shifted.
                {scratch_d, shreg_d} = {scratch_adj[BCD_W-2:0], shreg_q, 1'b0};
                cnt_d = cnt_q + CNT_LW'(1);
                if (cnt_q == LAST_IT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = scratch_q;
                ovf_d   = ovf_next_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            scratch_q  <= '0;
            ovf_next_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            ovf_next_q <= ovf_next_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = (state_q == ST_SHIFT);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed scenarios plus random values checked
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst;
    int   vectors    = 0;
    int   miscompares = 0;

    bin_to_bcd_seq_if #(.BIN_WIDTH(14)) bus ();

    bin_to_bcd_seq #(.BIN_WIDTH(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // Starts one conversion from idle; lat = negedges after the accepting edge
    // until done is seen (-1 on timeout), done_after = done one cycle later.
    task automatic run_conv(input int v, output int lat, output logic [15:0] bcd,
                            output logic ovf, output logic busy0, output logic done_after);
        int k;
        bus.start  = 1'b1;
        bus.bin_in = 14'(v);
        @(negedge clk);
        bus.start  = 1'b0;
        busy0 = bus.busy;
        k = 0;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        lat = bus.done ? k : -1;
        bcd = bus.bcd_out;
        ovf = bus.overflow;
        @(negedge clk);
        done_after = bus.done;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.bin_in = '0; rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        vectors++; if (bus.bcd_out !== 16'h0000) begin miscompares++; $display("FAIL reset_bcd got=%h exp=0000", bus.bcd_out); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lat; logic [15:0] b; logic o, b0, da;
        run_conv(1234, lat, b, o, b0, da);
        vectors++; if (lat !== 15) begin miscompares++; $display("FAIL single_latency got=%0d exp=15", lat); end
        vectors++; if (b !== 16'h1234) begin miscompares++; $display("FAIL single_bcd got=%h exp=1234", b); end
        vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL single_ovf got=%b exp=0", o); end
        vectors++; if (b0 !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", b0); end
        vectors++; if (da !== 1'b0) begin miscompares++; $display("FAIL single_done_width got=%b exp=0", da); end
    endtask

    task automatic test_back_to_back();
        int k, nd;
        int t[3];
        logic [15:0] got[3];
        logic        gov[3];
        logic [15:0] exp_v[3];
        exp_v[0] = 16'h0000; exp_v[1] = 16'h9999; exp_v[2] = 16'h0010;
        bus.start = 1'b1; bus.bin_in = 14'd0;
        @(negedge clk);
        bus.bin_in = 14'd9999;
        k = 0; nd = 0;
        while (nd < 3 && k < 80) begin
            if (bus.done) begin
                t[nd] = k; got[nd] = bus.bcd_out; gov[nd] = bus.overflow;
                nd++;
                if (nd == 3) bus.start = 1'b0;
            end
            if (nd == 1 && k == t[0] + 1) bus.bin_in = 14'd10;
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        vectors++; if (nd !== 3) begin miscompares++; $display("FAIL b2b_count got=%0d exp=3", nd); end
        for (int i = 0; i < nd; i++) begin
            vectors++; if (got[i] !== exp_v[i]) begin miscompares++; $display("FAIL b2b_bcd%0d got=%h exp=%h", i, got[i], exp_v[i]); end
            vectors++; if (gov[i] !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf%0d got=%b exp=0", i, gov[i]); end
        end
        for (int i = 1; i < nd; i++) begin
            vectors++; if (t[i] - t[i-1] !== 16) begin miscompares++; $display("FAIL b2b_spacing%0d got=%0d exp=16", i, t[i] - t[i-1]); end
        end
        @(negedge clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_stopped got=%b exp=0", bus.busy); end
    endtask

    task automatic test_saturation();
        int lat; logic [15:0] b; logic o, b0, da;
        run_conv(12000, lat, b, o, b0, da);
        vectors++; if (b !== 16'h9999) begin miscompares++; $display("FAIL sat_bcd got=%h exp=9999", b); end
        vectors++; if (o !== 1'b1) begin miscompares++; $display("FAIL sat_ovf got=%b exp=1", o); end
        run_conv(42, lat, b, o, b0, da);
        vectors++; if (b !== 16'h0042) begin miscompares++; $display("FAIL sat_next_bcd got=%h exp=0042", b); end
        vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL sat_next_ovf got=%b exp=0", o); end
    endtask

    task automatic test_ignore_busy();
        int nd;
        logic [15:0] b;
        bus.start = 1'b1; bus.bin_in = 14'd555;
        @(negedge clk);
        bus.start = 1'b0;
        nd = 0; b = '0;
        for (int k = 0; k < 40; k++) begin
            if (k == 5) begin bus.start = 1'b1; bus.bin_in = 14'd777; end
            if (k == 6) bus.start = 1'b0;
            if (bus.done) begin nd++; b = bus.bcd_out; end
            @(negedge clk);
        end
        vectors++; if (nd !== 1) begin miscompares++; $display("FAIL busy_ignore_count got=%0d exp=1", nd); end
        vectors++; if (b !== 16'h0555) begin miscompares++; $display("FAIL busy_ignore_bcd got=%h exp=0555", b); end
    endtask

    task automatic test_reset_mid();
        int nd, lat; logic [15:0] b; logic o, b0, da;
        bus.start = 1'b1; bus.bin_in = 14'd8765;
        @(negedge clk);
        bus.start = 1'b0;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 7) rst = 1'b1;
            if (k == 8) rst = 1'b0;
            if (bus.done) nd++;
            @(negedge clk);
        end
        vectors++; if (nd !== 0) begin miscompares++; $display("FAIL rstmid_done got=%0d exp=0", nd); end
        vectors++; if (bus.bcd_out !== 16'h0000) begin miscompares++; $display("FAIL rstmid_bcd got=%h exp=0000", bus.bcd_out); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        run_conv(321, lat, b, o, b0, da);
        vectors++; if (lat !== 15) begin miscompares++; $display("FAIL rstmid_next_latency got=%0d exp=15", lat); end
        vectors++; if (b !== 16'h0321) begin miscompares++; $display("FAIL rstmid_next_bcd got=%h exp=0321", b); end
    endtask

    task automatic test_random();
        int lat, v; logic [15:0] b; logic o, b0, da;
        for (int i = 0; i < 40; i++) begin
            v = (i % 4 == 0) ? int'($urandom_range(16383, 10000)) : int'($urandom_range(9999, 0));
            run_conv(v, lat, b, o, b0, da);
            vectors++; if (b !== ref_bcd(v)) begin miscompares++; $display("FAIL rand_bcd in=%0d got=%h exp=%h", v, b, ref_bcd(v)); end
            vectors++; if (o !== (v > 9999)) begin miscompares++; $display("FAIL rand_ovf in=%0d got=%b exp=%b", v, o, (v > 9999)); end
            vectors++; if (lat !== 15) begin miscompares++; $display("FAIL rand_latency in=%0d got=%0d exp=15", v, lat); end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.bin_in = '0; rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
